// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Data-memory slave for the core's load/store port. It accepts one request
//   at a time over a valid/ready handshake. It then inserts WAIT_CYCLES wait
//   states and commits the access to a word-organised RAM, applying byte-lane
//   enables on stores. Finally it presents the load data and an error flag on
//   a valid/ready response channel, holding them until the requester takes
//   them.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words stored (power of two, >= 4)
//   WAIT_CYCLES  wait states between request acceptance and response (0..15)
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-high reset (control and response registers
//              only; RAM contents survive)
//   req_valid  requester presents a request
//   req_ready  responder can accept a request this cycle (IDLE)
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index = req_addr[log2(DEPTH_WORDS)+1:2]
//   req_wdata  store data, lane i = bits [8i+7:8i]
//   req_be     store byte-lane enables (ignored for loads)
//   rsp_valid  response available (RESP)
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data, 0 for stores and errored accesses
//   rsp_err    access error flag
//   busy       a request is in flight (state != IDLE)
//
// Configuration:
//   DMEM_ERR_EN  when defined, misaligned addresses and addresses at or beyond
//                4*DEPTH_WORDS are flagged on rsp_err. No RAM write happens
//                for them and they return zero data. When undefined, rsp_err
//                is constant 0, addr[1:0] is ignored and upper address bits
//                alias into the RAM.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;

    logic            accept;
    logic            commit;
    logic            req_err;

    // Request captured at acceptance
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    // Replace only the enabled byte lanes of the stored word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

`ifdef DMEM_ERR_EN
    // Out of range is equivalent to any address bit above the word index
    // being set.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
    assign req_err = 1'b0;
    // Byte offset and upper bits are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    assign accept = (state == S_IDLE) && req_valid;

    // The counter is loaded with WAIT_CYCLES and must run down to zero before
    // the commit edge. The access is therefore always separated from
    // acceptance by WAIT_CYCLES wait states plus the commit edge. This gives
    // a response latency of 1 + WAIT_CYCLES and a minimum of one cycle when
    // WAIT_CYCLES is 0.
    assign commit = (state == S_WAIT) && (cnt == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= WAIT_LOAD;
            end else if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid) state_next = S_WAIT;
            S_WAIT: if (cnt == '0) state_next = S_RESP;
            S_RESP: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    // ---------------- Request capture ----------------
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= req_err;
        end
    end

    // ---------------- RAM commit ----------------
    // RST suppresses the write, which discards a store still waiting.
    // A store already committed on an earlier edge is left untouched.
    always_ff @(posedge CLK) begin
        if (!RST && commit && we_q && !err_q) begin
            mem[idx_q] <= merge_lanes(mem[idx_q], wdata_q, be_q);
        end
    end

    // ---------------- Response registers ----------------
    // Loaded only on the commit edge, so they stay stable throughout RESP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_err   <= err_q;
            rsp_rdata <= (we_q || err_q) ? 32'h0 : mem[idx_q];
        end
    end

endmodule
